// File: rtl/upsizer.sv
// Narrow-to-wide packer: RATIO beats of DATA_IN_WIDTH bytes form one DATA_OUT_WIDTH-byte word.
// Optional early completion on last_in when UPSIZER_PARTIAL_FLUSH_EN is defined.

module upsizer_lane #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         cur,
    input  logic         zero,
    input  logic [W-1:0] din,
    output logic [W-1:0] word
);
    logic [W-1:0] asm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        asm_q <= '0;
        else if (wr_en) asm_q <= din;
    end

    // The completing beat bypasses the assembly register so the word can move out on the same edge.
    assign word = zero ? '0 : (cur ? din : asm_q);
endmodule

module upsizer #(
    parameter int DATA_IN_WIDTH  = 32,
    parameter int DATA_OUT_WIDTH = 128,
    parameter int BEAT_CNT_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_IN_WIDTH*8-1:0]  data_in,
    input  logic                        valid_in,
    input  logic                        last_in,
    output logic                        in_ready,
    output logic [DATA_OUT_WIDTH*8-1:0] data_out,
    output logic [(1<<BEAT_CNT_WIDTH)-1:0] keep_out,
    output logic                        out_en,
    input  logic                        out_ready
);
    localparam int RATIO = 1 << BEAT_CNT_WIDTH;
    localparam int LW    = DATA_IN_WIDTH * 8;

    logic [BEAT_CNT_WIDTH-1:0]   beat_cnt;
    logic                        last_beat, flush_req, accept, complete;
    logic [RATIO-1:0][LW-1:0]    word_nxt;
    logic [RATIO-1:0][LW-1:0]    data_q;
    logic [RATIO-1:0]            keep_nxt;

    assign last_beat = (beat_cnt == BEAT_CNT_WIDTH'(RATIO - 1));

`ifdef UPSIZER_PARTIAL_FLUSH_EN
    assign flush_req = valid_in && last_in;
`else
    logic unused_last;
    assign unused_last = last_in;
    assign flush_req   = 1'b0;
`endif

    // Only a completing beat needs the output register, so only it waits on a stalled sink.
    assign in_ready = !rst && !(out_en && !out_ready && (last_beat || flush_req));
    assign accept   = valid_in && in_ready;
    assign complete = accept && (last_beat || flush_req);

    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        logic cur, zero;
        assign cur         = (beat_cnt == BEAT_CNT_WIDTH'(i));
        assign zero        = (BEAT_CNT_WIDTH'(i) > beat_cnt);
        assign keep_nxt[i] = !zero;

        upsizer_lane #(.W(LW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr_en (accept && cur),
            .cur   (cur),
            .zero  (zero),
            .din   (data_in),
            .word  (word_nxt[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            data_q   <= '0;
            keep_out <= '0;
            out_en   <= 1'b0;
        end else begin
            if (accept)
                beat_cnt <= complete ? '0 : beat_cnt + 1'b1;
            // A completion on the draining edge replaces the old word with no bubble.
            if (complete) begin
                data_q   <= word_nxt;
                keep_out <= keep_nxt;
                out_en   <= 1'b1;
            end else if (out_en && out_ready) begin
                out_en   <= 1'b0;
            end
        end
    end

    assign data_out = data_q;
endmodule

// File: tb/tb_upsizer.sv
// Directed bench for upsizer: fill, back-to-back, stall, mid-run reset and last_in handling.

module tb_upsizer;
    logic          clk = 1'b0;
    logic          rst;
    logic [255:0]  data_in;
    logic          valid_in, last_in, in_ready, out_en, out_ready;
    logic [1023:0] data_out;
    logic [3:0]    keep_out;

    int checks = 0;
    int errors = 0;

    upsizer dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .out_en    (out_en),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] lane(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic logic [1023:0] word4(input logic [7:0] b3, b2, b1, b0);
        return {lane(b3), lane(b2), lane(b1), lane(b0)};
    endfunction

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat, verify it is offered in_ready, then clock it in.
    task automatic beat(input string tag, input logic [7:0] b, input logic l);
        valid_in = 1'b1;
        last_in  = l;
        data_in  = lane(b);
        #1;
        chk(tag, 1024'(in_ready), 1024'(1'b1));
        tick();
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; last_in = 1'b0; data_in = '0; out_ready = 1'b1;
        tick();
        chk("rst_in_ready", 1024'(in_ready), 1024'(1'b0));
        chk("rst_out_en",   1024'(out_en),   1024'(1'b0));
        chk("rst_data",     data_out,        '0);
        chk("rst_keep",     1024'(keep_out), 1024'(4'b0000));
        rst = 1'b0;
        tick();

        // Basic fill: lane 0 gets the first beat
        beat("t1_b1", 8'h11, 1'b0);
        chk("t1_noout1", 1024'(out_en), 1024'(1'b0));
        beat("t1_b2", 8'h22, 1'b0);
        beat("t1_b3", 8'h33, 1'b0);
        chk("t1_noout3", 1024'(out_en), 1024'(1'b0));
        beat("t1_b4", 8'h44, 1'b0);
        chk("t1_out_en", 1024'(out_en),   1024'(1'b1));
        chk("t1_data",   data_out,        word4(8'h44, 8'h33, 8'h22, 8'h11));
        chk("t1_keep",   1024'(keep_out), 1024'(4'b1111));
        tick();
        chk("t1_drop",   1024'(out_en),   1024'(1'b0));

        // Eight back-to-back beats: two single-cycle words four cycles apart
        for (int k = 1; k <= 8; k++) begin
            beat("t2_rdy", 8'(k), 1'b0);
            chk("t2_out_en", 1024'(out_en), 1024'((k == 4) || (k == 8)));
            if (k == 4) chk("t2_w1", data_out, word4(8'h04, 8'h03, 8'h02, 8'h01));
            if (k == 8) chk("t2_w2", data_out, word4(8'h08, 8'h07, 8'h06, 8'h05));
        end
        tick();
        chk("t2_drop", 1024'(out_en), 1024'(1'b0));

        // Output stall: beats 5-7 still accepted, beat 8 waits
        for (int k = 0; k < 4; k++) beat("t3_a", 8'hA0 + 8'(k), 1'b0);
        chk("t3_w1_en", 1024'(out_en), 1024'(1'b1));
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat("t3_b", 8'hB0 + 8'(k), 1'b0);
            chk("t3_hold_en",   1024'(out_en), 1024'(1'b1));
            chk("t3_hold_data", data_out, word4(8'hA3, 8'hA2, 8'hA1, 8'hA0));
        end
        valid_in = 1'b1; data_in = lane(8'hB3);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_blocked",   1024'(in_ready), 1024'(1'b0));
            tick();
            chk("t3_hold_data", data_out, word4(8'hA3, 8'hA2, 8'hA1, 8'hA0));
            chk("t3_hold_keep", 1024'(keep_out), 1024'(4'b1111));
        end
        out_ready = 1'b1;
        #1;
        chk("t3_unblocked", 1024'(in_ready), 1024'(1'b1));
        tick();
        valid_in = 1'b0;
        chk("t3_w2_en",   1024'(out_en), 1024'(1'b1));
        chk("t3_w2_data", data_out, word4(8'hB3, 8'hB2, 8'hB1, 8'hB0));
        tick();
        chk("t3_drop", 1024'(out_en), 1024'(1'b0));

        // Mid-word reset discards the partial word and clears the held output
        beat("t4_c1", 8'hC0, 1'b0);
        beat("t4_c2", 8'hC1, 1'b0);
        rst = 1'b1;
        #1;
        chk("t4_rst_en",    1024'(out_en),   1024'(1'b0));
        chk("t4_rst_data",  data_out,        '0);
        chk("t4_rst_rdy",   1024'(in_ready), 1024'(1'b0));
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            beat("t4_d", 8'hD0 + 8'(k), 1'b0);
            chk("t4_out_en", 1024'(out_en), 1024'(k == 3));
        end
        chk("t4_data", data_out, word4(8'hD3, 8'hD2, 8'hD1, 8'hD0));
        chk("t4_keep", 1024'(keep_out), 1024'(4'b1111));
        tick();

`ifdef UPSIZER_PARTIAL_FLUSH_EN
        beat("t5_a", 8'hE0, 1'b0);
        beat("t5_b", 8'hE1, 1'b1);
        chk("t5_en",   1024'(out_en),   1024'(1'b1));
        chk("t5_data", data_out,        word4(8'h00, 8'h00, 8'hE1, 8'hE0));
        chk("t5_keep", 1024'(keep_out), 1024'(4'b0011));
        tick();
        for (int k = 0; k < 4; k++) beat("t5_f", 8'hF0 + 8'(k), 1'b0);
        chk("t5_full_en",   1024'(out_en),   1024'(1'b1));
        chk("t5_full_data", data_out, word4(8'hF3, 8'hF2, 8'hF1, 8'hF0));
        chk("t5_full_keep", 1024'(keep_out), 1024'(4'b1111));
`else
        beat("t6_b1", 8'hE0, 1'b0);
        beat("t6_b2", 8'hE1, 1'b1);
        chk("t6_no_early", 1024'(out_en), 1024'(1'b0));
        beat("t6_b3", 8'hE2, 1'b0);
        chk("t6_no_out3",  1024'(out_en), 1024'(1'b0));
        beat("t6_b4", 8'hE3, 1'b0);
        chk("t6_en",   1024'(out_en),   1024'(1'b1));
        chk("t6_data", data_out,        word4(8'hE3, 8'hE2, 8'hE1, 8'hE0));
        chk("t6_keep", 1024'(keep_out), 1024'(4'b1111));
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
